// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write ports, PC/CSPR loads, reservation.
// Latency and backpressure are set by the register file itself. This bundle only groups the wires.
// The master modport is the issue/writeback side. The slave modport is the register file.
interface regfile_sb_if #(
   parameter int N  = 32,
   parameter int AW = 4
);
   localparam int NREG = 2**AW;

   logic [AW-1:0]   in_address1, in_address2, in_address3, in_address4;
   logic [N-1:0]    out_data1, out_data2, out_data3, out_data4;
   logic            out_busy1, out_busy2, out_busy3, out_busy4;
   logic [AW-1:0]   write_address, write_address2;
   logic [N-1:0]    write_data, write_data2;
   logic            write_enable, write_enable2;
   logic [N-1:0]    pc_update;
   logic            pc_write;
   logic [N-1:0]    pc;
   logic [N-1:0]    cspr_update;
   logic            cspr_write;
   logic [N-1:0]    cspr;
   logic            rsv_valid;
   logic [AW-1:0]   rsv_address;
   logic            rsv_ok;
   logic [NREG-1:0] busy;

   modport master (
      output in_address1, in_address2, in_address3, in_address4,
      input  out_data1, out_data2, out_data3, out_data4,
      input  out_busy1, out_busy2, out_busy3, out_busy4,
      output write_address, write_address2, write_data, write_data2,
      output write_enable, write_enable2,
      output pc_update, pc_write, cspr_update, cspr_write,
      input  pc, cspr,
      output rsv_valid, rsv_address,
      input  rsv_ok, busy
   );

   modport slave (
      input  in_address1, in_address2, in_address3, in_address4,
      output out_data1, out_data2, out_data3, out_data4,
      output out_busy1, out_busy2, out_busy3, out_busy4,
      input  write_address, write_address2, write_data, write_data2,
      input  write_enable, write_enable2,
      input  pc_update, pc_write, cspr_update, cspr_write,
      output pc, cspr,
      input  rsv_valid, rsv_address,
      output rsv_ok, busy
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file (2**AW x N) with PC alias, CSPR and per-register reservation scoreboard.
// Latency: reads and writes take 1 cycle, with write-first bypass onto the read ports. rsv_ok is combinational.
// Backpressure: none on writes. A reservation is refused (rsv_ok=0) while the target is busy or is the PC, and the requester retries.
// Ports: clk, rst (async, active high), and bus (regfile_sb_if.slave) carrying everything else.
module regfile_sb #(
   parameter int N      = 32,
   parameter int AW     = 4,
   parameter int PC_IDX = 2**AW - 1
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);
   localparam int NREG = 2**AW;
   localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

   logic [N-1:0]    r_q [NREG];
   logic [N-1:0]    r_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [N-1:0]    cspr_q, cspr_d;
   logic [N-1:0]    out_data_q [4];
   logic [N-1:0]    out_data_d [4];
   logic [3:0]      out_busy_q, out_busy_d;
   logic [AW-1:0]   rd_addr [4];
   logic            rsv_ok;

   assign rd_addr[0] = bus.in_address1;
   assign rd_addr[1] = bus.in_address2;
   assign rd_addr[2] = bus.in_address3;
   assign rd_addr[3] = bus.in_address4;

   // Looks only at current state, so a same-cycle write cannot free a register for reservation.
   assign rsv_ok = bus.rsv_valid & ~busy_q[bus.rsv_address] & (bus.rsv_address != PC_ADDR);

   always_comb begin
      cspr_d = bus.cspr_write ? bus.cspr_update : cspr_q;
      for (int i = 0; i < NREG; i++) begin
         r_d[i]    = r_q[i];
         busy_d[i] = busy_q[i];
         // Later assignments win: write_enable2 > write_enable > pc_write.
         if (bus.pc_write && i == PC_IDX)
            r_d[i] = bus.pc_update;
         if (bus.write_enable && bus.write_address == AW'(i))
            r_d[i] = bus.write_data;
         if (bus.write_enable2 && bus.write_address2 == AW'(i))
            r_d[i] = bus.write_data2;
         if ((bus.write_enable && bus.write_address == AW'(i)) ||
             (bus.write_enable2 && bus.write_address2 == AW'(i)))
            busy_d[i] = 1'b0;
         // A new producer overrides the completing one on the same edge.
         if (rsv_ok && bus.rsv_address == AW'(i))
            busy_d[i] = 1'b1;
      end
      // Write-first: read ports sample next-state values.
      for (int k = 0; k < 4; k++) begin
         out_data_d[k] = r_d[rd_addr[k]];
         out_busy_d[k] = busy_d[rd_addr[k]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_q[i] <= '0;
         for (int k = 0; k < 4; k++) out_data_q[k] <= '0;
         busy_q     <= '0;
         cspr_q     <= '0;
         out_busy_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) r_q[i] <= r_d[i];
         for (int k = 0; k < 4; k++) out_data_q[k] <= out_data_d[k];
         busy_q     <= busy_d;
         cspr_q     <= cspr_d;
         out_busy_q <= out_busy_d;
      end
   end

   assign bus.out_data1 = out_data_q[0];
   assign bus.out_data2 = out_data_q[1];
   assign bus.out_data3 = out_data_q[2];
   assign bus.out_data4 = out_data_q[3];
   assign bus.out_busy1 = out_busy_q[0];
   assign bus.out_busy2 = out_busy_q[1];
   assign bus.out_busy3 = out_busy_q[2];
   assign bus.out_busy4 = out_busy_q[3];
   assign bus.pc        = r_q[PC_IDX];
   assign bus.cspr      = cspr_q;
   assign bus.busy      = busy_q;
   assign bus.rsv_ok    = rsv_ok;
endmodule
